// File: rtl/branch_resolve.sv
`default_nettype none
// ==========================================================================
// branch_resolve : execute-stage branch resolution with front-end redirect
//                  and a predictor-update FIFO
// Revision       : 1.0  initial release
// ==========================================================================
module branch_resolve #(
  parameter int AW      = 32,
  parameter int XLEN    = 64,
  parameter int Q_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic            ex_is_branch,
  input  logic            ex_is_jal,
  input  logic            ex_is_jalr,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_rs2,
  input  logic [31:0]     ex_imm,
  input  logic [AW-1:0]   ex_pc,
  input  logic            ex_pred_hit,
  input  logic            ex_pred_taken,
  input  logic [AW-1:0]   ex_pred_target,
  output logic            redirect_valid,
  output logic [AW-1:0]   redirect_pc,
  output logic            upd_valid,
  input  logic            upd_ready,
  output logic [AW-1:0]   upd_pc,
  output logic [AW-1:0]   upd_target,
  output logic            upd_taken,
  output logic            upd_mispred,
  output logic [31:0]     br_count,
  output logic [31:0]     mispred_count
);

  localparam int C_PTR_W = $clog2(Q_DEPTH);
  localparam int C_CNT_W = C_PTR_W + 1;
  localparam logic [C_CNT_W-1:0] C_DEPTH = C_CNT_W'(Q_DEPTH);

  // ---------------- stage 1: combinational resolution ----------------
  logic          w_accept;
  logic          w_cond;
  logic          w_f3_legal;
  logic          w_is_cf;
  logic          w_taken;
  logic          w_pred_taken;
  logic          w_mispred;
  logic          w_s1_valid;
  logic          w_redirect;
  logic [AW-1:0] w_imm;
  logic [AW-1:0] w_jalr_sum;
  logic [AW-1:0] w_target;
  logic [AW-1:0] w_fallthru;

  assign w_accept = ex_valid & ex_ready;
  assign w_imm    = ex_imm[AW-1:0];

  always_comb begin
    w_cond     = 1'b0;
    w_f3_legal = 1'b1;
    case (ex_funct3)
      3'b000:  w_cond = (ex_rs1 == ex_rs2);
      3'b001:  w_cond = (ex_rs1 != ex_rs2);
      3'b100:  w_cond = ($signed(ex_rs1) <  $signed(ex_rs2));
      3'b101:  w_cond = ($signed(ex_rs1) >= $signed(ex_rs2));
      3'b110:  w_cond = (ex_rs1 <  ex_rs2);
      3'b111:  w_cond = (ex_rs1 >= ex_rs2);
      default: w_f3_legal = 1'b0;
    endcase
  end

  assign w_is_cf      = ex_is_jal | ex_is_jalr | (ex_is_branch & w_f3_legal);
  assign w_taken      = ex_is_jal | ex_is_jalr | (ex_is_branch & w_cond);
  assign w_jalr_sum   = ex_rs1[AW-1:0] + w_imm;
  assign w_target     = ex_is_jalr ? {w_jalr_sum[AW-1:1], 1'b0} : (ex_pc + w_imm);
  assign w_fallthru   = ex_pc + AW'(4);
  assign w_pred_taken = ex_pred_hit & ex_pred_taken;
  assign w_mispred    = (w_taken != w_pred_taken) |
                        (w_taken & w_pred_taken & (ex_pred_target != w_target));
  // Anything accepted while a redirect is being signalled is wrong-path.
  assign w_s1_valid   = w_accept & w_is_cf & ~w_redirect;

  // ---------------- stage 2 register ----------------
  logic          r_s2_valid;
  logic          r_s2_taken;
  logic          r_s2_mispred;
  logic [AW-1:0] r_s2_pc;
  logic [AW-1:0] r_s2_target;
  logic [AW-1:0] r_redirect_pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s2_valid    <= 1'b0;
      r_s2_taken    <= 1'b0;
      r_s2_mispred  <= 1'b0;
      r_s2_pc       <= '0;
      r_s2_target   <= '0;
      r_redirect_pc <= '0;
    end else begin
      r_s2_valid <= w_s1_valid;
      if (w_s1_valid) begin
        r_s2_taken    <= w_taken;
        r_s2_mispred  <= w_mispred;
        r_s2_pc       <= ex_pc;
        r_s2_target   <= w_target;
        r_redirect_pc <= w_taken ? w_target : w_fallthru;
      end
    end
  end

  assign w_redirect     = r_s2_valid & r_s2_mispred;
  assign redirect_valid = w_redirect;
  assign redirect_pc    = r_redirect_pc;

  // ---------------- update FIFO ----------------
  logic [AW-1:0]      r_q_pc      [Q_DEPTH];
  logic [AW-1:0]      r_q_target  [Q_DEPTH];
  logic               r_q_taken   [Q_DEPTH];
  logic               r_q_mispred [Q_DEPTH];
  logic [C_PTR_W-1:0] r_wr_ptr;
  logic [C_PTR_W-1:0] r_rd_ptr;
  logic [C_CNT_W-1:0] r_count;
  logic               w_push;
  logic               w_pop;
  logic [C_CNT_W-1:0] w_occupancy;

  assign w_push      = r_s2_valid;
  assign w_pop       = upd_ready & (r_count != '0);
  // Stage 2 holds a slot in reserve, so a push can never find the FIFO full.
  assign w_occupancy = r_count + C_CNT_W'(r_s2_valid);
  assign ex_ready    = (w_occupancy < C_DEPTH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < Q_DEPTH; i++) begin
        r_q_pc[i]      <= '0;
        r_q_target[i]  <= '0;
        r_q_taken[i]   <= 1'b0;
        r_q_mispred[i] <= 1'b0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_q_pc[r_wr_ptr]      <= r_s2_pc;
        r_q_target[r_wr_ptr]  <= r_s2_target;
        r_q_taken[r_wr_ptr]   <= r_s2_taken;
        r_q_mispred[r_wr_ptr] <= r_s2_mispred;
        r_wr_ptr              <= r_wr_ptr + C_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_CNT_W'(1);
        2'b01:   r_count <= r_count - C_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign upd_valid   = (r_count != '0);
  assign upd_pc      = r_q_pc[r_rd_ptr];
  assign upd_target  = r_q_target[r_rd_ptr];
  assign upd_taken   = r_q_taken[r_rd_ptr];
  assign upd_mispred = r_q_mispred[r_rd_ptr];

  // ---------------- saturating statistics ----------------
  logic [31:0] r_br_count;
  logic [31:0] r_mispred_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_br_count      <= '0;
      r_mispred_count <= '0;
    end else if (w_push) begin
      if (r_br_count != 32'hFFFF_FFFF) begin
        r_br_count <= r_br_count + 32'd1;
      end
      if (r_s2_mispred && (r_mispred_count != 32'hFFFF_FFFF)) begin
        r_mispred_count <= r_mispred_count + 32'd1;
      end
    end
  end

  assign br_count      = r_br_count;
  assign mispred_count = r_mispred_count;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve.sv
`default_nettype none
// ==========================================================================
// tb_branch_resolve : directed and randomized bench for branch_resolve
// Revision          : 1.0  initial release
// ==========================================================================
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic        ex_is_branch = 1'b0, ex_is_jal = 1'b0, ex_is_jalr = 1'b0;
  logic [2:0]  ex_funct3 = '0;
  logic [63:0] ex_rs1 = '0, ex_rs2 = '0;
  logic [31:0] ex_imm = '0, ex_pc = '0;
  logic        ex_pred_hit = 1'b0, ex_pred_taken = 1'b0;
  logic [31:0] ex_pred_target = '0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic        upd_ready = 1'b0;
  logic [31:0] upd_pc, upd_target;
  logic        upd_taken, upd_mispred;
  logic [31:0] br_count, mispred_count;

  int n_checks = 0;
  int n_fail   = 0;

  branch_resolve #(.AW(32), .XLEN(64), .Q_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
    .ex_funct3(ex_funct3), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_imm(ex_imm),
    .ex_pc(ex_pc), .ex_pred_hit(ex_pred_hit), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_taken(upd_taken), .upd_mispred(upd_mispred),
    .br_count(br_count), .mispred_count(mispred_count)
  );

  always #5 clk = ~clk;

  // Transaction-level reference: pending resolved entry, update queue, counters.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
    logic        mispred;
  } ent_t;

  ent_t        m_q[$];
  ent_t        m_s2;
  bit          m_s2_valid;
  logic [31:0] m_br, m_mis;

  function automatic void model_reset();
    m_q.delete();
    m_s2       = '0;
    m_s2_valid = 0;
    m_br       = '0;
    m_mis      = '0;
  endfunction

  function automatic bit model_ready();
    return (m_q.size() + (m_s2_valid ? 1 : 0)) < 4;
  endfunction

  function automatic bit model_redirect();
    return m_s2_valid && m_s2.mispred;
  endfunction

  // Resolves the instruction currently on the ex_* inputs; returns 0 if it has no effect.
  function automatic bit resolve(output ent_t e);
    logic signed [63:0] s1, s2;
    bit cond, legal, pt;
    s1 = ex_rs1;
    s2 = ex_rs2;
    e = '0;
    cond = 0;
    legal = 1;
    case (ex_funct3)
      3'd0: cond = (ex_rs1 == ex_rs2);
      3'd1: cond = (ex_rs1 != ex_rs2);
      3'd4: cond = (s1 < s2);
      3'd5: cond = (s1 >= s2);
      3'd6: cond = (ex_rs1 < ex_rs2);
      3'd7: cond = (ex_rs1 >= ex_rs2);
      default: legal = 0;
    endcase
    e.pc = ex_pc;
    if (ex_is_jalr) begin
      e.taken  = 1;
      e.target = (ex_rs1[31:0] + ex_imm) & 32'hFFFF_FFFE;
      legal    = 1;
    end else if (ex_is_jal) begin
      e.taken  = 1;
      e.target = ex_pc + ex_imm;
      legal    = 1;
    end else if (ex_is_branch) begin
      e.taken  = cond;
      e.target = ex_pc + ex_imm;
    end else begin
      legal = 0;
    end
    pt = ex_pred_hit && ex_pred_taken;
    e.mispred = (e.taken != pt) || (e.taken && pt && (ex_pred_target != e.target));
    return legal;
  endfunction

  // Advance the reference by one clock using the current inputs, then step the DUT.
  task automatic tick();
    ent_t e;
    bit   nv;
    nv = 0;
    e  = '0;
    if (ex_valid && model_ready() && !model_redirect()) nv = resolve(e);
    if (upd_ready && m_q.size() > 0) void'(m_q.pop_front());
    if (m_s2_valid) begin
      m_q.push_back(m_s2);
      if (m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
      if (m_s2.mispred && m_mis != 32'hFFFF_FFFF) m_mis = m_mis + 1;
    end
    m_s2_valid = nv;
    m_s2       = e;
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    ex_valid = 0; ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0;
  endtask

  task automatic drive(input bit br, input bit jal, input bit jalr, input logic [2:0] f3,
                       input logic [63:0] rs1, input logic [63:0] rs2,
                       input logic [31:0] imm, input logic [31:0] pc,
                       input bit hit, input bit pt, input logic [31:0] ptgt);
    ex_valid = 1; ex_is_branch = br; ex_is_jal = jal; ex_is_jalr = jalr;
    ex_funct3 = f3; ex_rs1 = rs1; ex_rs2 = rs2; ex_imm = imm; ex_pc = pc;
    ex_pred_hit = hit; ex_pred_taken = pt; ex_pred_target = ptgt;
  endtask

  task automatic drain();
    set_idle();
    upd_ready = 1;
    repeat (6) tick();
    upd_ready = 0;
  endtask

  task automatic test_reset();
    rst = 0;
    set_idle();
    upd_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ex_ready: got %b expected 1", ex_ready); end
    n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL reset_redirect_valid: got %b expected 0", redirect_valid); end
    n_checks++; if (redirect_pc !== 32'h0) begin n_fail++; $display("FAIL reset_redirect_pc: got %h expected 0", redirect_pc); end
    n_checks++; if (upd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_upd_valid: got %b expected 0", upd_valid); end
    n_checks++; if ({upd_pc, upd_target, upd_taken, upd_mispred} !== '0) begin n_fail++; $display("FAIL reset_upd_fields: got %h/%h/%b/%b expected zeros", upd_pc, upd_target, upd_taken, upd_mispred); end
    n_checks++; if ({br_count, mispred_count} !== 64'h0) begin n_fail++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", br_count, mispred_count); end
    rst = 1;
    model_reset();
    tick();
  endtask

  task automatic test_beq();
    drive(1, 0, 0, 3'b000, 64'd5, 64'd5, 32'h40, 32'h100, 0, 0, 32'h0);
    tick();
    set_idle();
    n_checks++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL beq_redirect_valid: got %b expected 1", redirect_valid); end
    n_checks++; if (redirect_pc !== 32'h140) begin n_fail++; $display("FAIL beq_redirect_pc: got %h expected 140", redirect_pc); end
    tick();
    n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL beq_redirect_pulse: got %b expected 0", redirect_valid); end
    n_checks++; if (upd_valid !== 1'b1) begin n_fail++; $display("FAIL beq_upd_valid: got %b expected 1", upd_valid); end
    n_checks++; if (upd_pc !== 32'h100 || upd_target !== 32'h140) begin n_fail++; $display("FAIL beq_upd_pc_target: got %h/%h expected 100/140", upd_pc, upd_target); end
    n_checks++; if (upd_taken !== 1'b1 || upd_mispred !== 1'b1) begin n_fail++; $display("FAIL beq_upd_flags: got %b/%b expected 1/1", upd_taken, upd_mispred); end
    n_checks++; if (br_count !== 32'd1 || mispred_count !== 32'd1) begin n_fail++; $display("FAIL beq_counters: got %0d/%0d expected 1/1", br_count, mispred_count); end
    drain();
  endtask

  task automatic test_bne();
    drive(1, 0, 0, 3'b001, 64'd7, 64'd7, 32'h20, 32'h200, 1, 0, 32'h0);
    tick();
    set_idle();
    n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL bne_redirect_valid: got %b expected 0", redirect_valid); end
    tick();
    n_checks++; if (upd_valid !== 1'b1 || upd_taken !== 1'b0 || upd_mispred !== 1'b0) begin n_fail++; $display("FAIL bne_upd: got v%b t%b m%b expected v1 t0 m0", upd_valid, upd_taken, upd_mispred); end
    n_checks++; if (upd_target !== 32'h220) begin n_fail++; $display("FAIL bne_upd_target: got %h expected 220", upd_target); end
    n_checks++; if (br_count !== 32'd2 || mispred_count !== 32'd1) begin n_fail++; $display("FAIL bne_counters: got %0d/%0d expected 2/1", br_count, mispred_count); end
    drain();
  endtask

  task automatic test_jalr();
    drive(0, 0, 1, 3'b000, 64'h1003, 64'd0, 32'd4, 32'h300, 1, 1, 32'h1006);
    tick();
    set_idle();
    n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL jalr_hit_redirect: got %b expected 0", redirect_valid); end
    tick();
    n_checks++; if (upd_target !== 32'h1006 || upd_taken !== 1'b1 || upd_mispred !== 1'b0) begin n_fail++; $display("FAIL jalr_hit_upd: got %h t%b m%b expected 1006 t1 m0", upd_target, upd_taken, upd_mispred); end
    drain();
    drive(0, 0, 1, 3'b000, 64'h1003, 64'd0, 32'd4, 32'h300, 1, 1, 32'h1000);
    tick();
    set_idle();
    n_checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1006) begin n_fail++; $display("FAIL jalr_miss_redirect: got %b pc %h expected 1 pc 1006", redirect_valid, redirect_pc); end
    tick();
    n_checks++; if (upd_mispred !== 1'b1) begin n_fail++; $display("FAIL jalr_miss_upd: got %b expected 1", upd_mispred); end
    drain();
  endtask

  task automatic test_compare();
    drive(1, 0, 0, 3'b100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 32'h80, 32'h400, 0, 0, 32'h0);
    tick();
    set_idle();
    n_checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h480) begin n_fail++; $display("FAIL blt_redirect: got %b pc %h expected 1 pc 480", redirect_valid, redirect_pc); end
    drain();
    drive(1, 0, 0, 3'b110, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 32'h80, 32'h400, 0, 0, 32'h0);
    tick();
    set_idle();
    n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL bltu_redirect: got %b expected 0", redirect_valid); end
    tick();
    n_checks++; if (upd_taken !== 1'b0 || upd_mispred !== 1'b0 || upd_target !== 32'h480) begin n_fail++; $display("FAIL bltu_upd: got t%b m%b %h expected t0 m0 480", upd_taken, upd_mispred, upd_target); end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [31:0] pc;
    upd_ready = 0;
    for (int i = 0; i < 4; i++) begin
      pc = 32'h500 + 32'(16 * i);
      n_checks++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_before_%0d: got %b expected 1", i, ex_ready); end
      drive(1, 0, 0, 3'b000, 64'd1, 64'd1, 32'h8, pc, 1, 1, pc + 32'h8);
      tick();
    end
    set_idle();
    n_checks++; if (ex_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_after_4th: got %b expected 0", ex_ready); end
    tick();
    n_checks++; if (ex_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_full: got %b expected 0", ex_ready); end
    upd_ready = 1;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (upd_valid !== 1'b1 || upd_pc !== 32'h500 + 32'(16 * i)) begin n_fail++; $display("FAIL b2b_order_%0d: got v%b pc %h expected v1 pc %h", i, upd_valid, upd_pc, 32'h500 + 32'(16 * i)); end
      tick();
      if (i == 0) begin
        n_checks++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_after_pop: got %b expected 1", ex_ready); end
      end
    end
    n_checks++; if (upd_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty: got %b expected 0", upd_valid); end
    upd_ready = 0;
  endtask

  task automatic test_wrong_path();
    logic [31:0] b0, m0;
    b0 = br_count;
    m0 = mispred_count;
    drive(1, 0, 0, 3'b000, 64'd3, 64'd3, 32'h10, 32'h600, 0, 0, 32'h0);
    tick();
    n_checks++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL wp_redirect: got %b expected 1", redirect_valid); end
    drive(1, 0, 0, 3'b000, 64'd3, 64'd3, 32'h10, 32'h700, 0, 0, 32'h0);
    tick();
    set_idle();
    n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL wp_no_second_redirect: got %b expected 0", redirect_valid); end
    tick();
    n_checks++; if (br_count !== b0 + 1 || mispred_count !== m0 + 1) begin n_fail++; $display("FAIL wp_counters: got %0d/%0d expected %0d/%0d", br_count, mispred_count, b0 + 1, m0 + 1); end
    n_checks++; if (upd_pc !== 32'h600) begin n_fail++; $display("FAIL wp_head: got %h expected 600", upd_pc); end
    upd_ready = 1;
    tick();
    upd_ready = 0;
    n_checks++; if (upd_valid !== 1'b0) begin n_fail++; $display("FAIL wp_dropped_entry: got %b expected 0", upd_valid); end
  endtask

  task automatic test_random();
    ent_t        e, h;
    bit          legal;
    int          k;
    logic [63:0] vals[5];
    for (int c = 0; c < 400; c++) begin
      n_checks++; if (ex_ready !== model_ready()) begin n_fail++; $display("FAIL rnd_ex_ready cyc %0d: got %b expected %b", c, ex_ready, model_ready()); end
      n_checks++; if (redirect_valid !== model_redirect()) begin n_fail++; $display("FAIL rnd_redirect_valid cyc %0d: got %b expected %b", c, redirect_valid, model_redirect()); end
      if (model_redirect()) begin
        n_checks++; if (redirect_pc !== (m_s2.taken ? m_s2.target : m_s2.pc + 32'd4)) begin n_fail++; $display("FAIL rnd_redirect_pc cyc %0d: got %h expected %h", c, redirect_pc, m_s2.taken ? m_s2.target : m_s2.pc + 32'd4); end
      end
      n_checks++; if (upd_valid !== (m_q.size() != 0)) begin n_fail++; $display("FAIL rnd_upd_valid cyc %0d: got %b expected %b", c, upd_valid, m_q.size() != 0); end
      if (m_q.size() != 0) begin
        h = m_q[0];
        n_checks++; if ({upd_pc, upd_target, upd_taken, upd_mispred} !== h) begin n_fail++; $display("FAIL rnd_upd_head cyc %0d: got %h/%h/%b/%b expected %h/%h/%b/%b", c, upd_pc, upd_target, upd_taken, upd_mispred, h.pc, h.target, h.taken, h.mispred); end
      end
      n_checks++; if (br_count !== m_br || mispred_count !== m_mis) begin n_fail++; $display("FAIL rnd_counters cyc %0d: got %0d/%0d expected %0d/%0d", c, br_count, mispred_count, m_br, m_mis); end
      vals[0] = 64'd0; vals[1] = 64'd1; vals[2] = '1; vals[3] = 64'd5; vals[4] = {$urandom, $urandom};
      k = $urandom_range(0, 5);
      drive(k >= 1 && k <= 3, k == 4, k == 5, 3'($urandom_range(0, 7)),
            vals[$urandom_range(0, 4)], vals[$urandom_range(0, 4)],
            32'($signed(12'($urandom))), {$urandom_range(0, 4095), 2'b00},
            1'($urandom), 1'($urandom), $urandom);
      ex_valid = ($urandom_range(0, 3) != 0);
      legal = resolve(e);
      if (legal && $urandom_range(0, 3) != 0) ex_pred_target = e.target;
      upd_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    set_idle();
    drain();
  endtask

  task automatic test_reset_midop();
    upd_ready = 0;
    drive(1, 0, 0, 3'b000, 64'd2, 64'd2, 32'h4, 32'h800, 1, 1, 32'h804);
    tick();
    drive(1, 0, 0, 3'b000, 64'd2, 64'd2, 32'h4, 32'h810, 1, 1, 32'h814);
    tick();
    drive(1, 0, 0, 3'b000, 64'd2, 64'd2, 32'h4, 32'h820, 0, 0, 32'h0);
    tick();
    set_idle();
    n_checks++; if (redirect_valid !== 1'b1 || upd_valid !== 1'b1) begin n_fail++; $display("FAIL midop_pre: got redir %b upd %b expected 1/1", redirect_valid, upd_valid); end
    #2 rst = 0;
    #1;
    n_checks++; if (upd_valid !== 1'b0 || redirect_valid !== 1'b0) begin n_fail++; $display("FAIL midop_async_clear: got upd %b redir %b expected 0/0", upd_valid, redirect_valid); end
    n_checks++; if (br_count !== 32'd0 || mispred_count !== 32'd0 || ex_ready !== 1'b1) begin n_fail++; $display("FAIL midop_counters: got %0d/%0d ready %b expected 0/0 ready 1", br_count, mispred_count, ex_ready); end
    model_reset();
    @(posedge clk);
    #1 rst = 1;
    tick();
    n_checks++; if (redirect_valid !== 1'b0 || upd_valid !== 1'b0) begin n_fail++; $display("FAIL midop_after: got redir %b upd %b expected 0/0", redirect_valid, upd_valid); end
  endtask

  initial begin
    test_reset();
    test_beq();
    test_bne();
    test_jalr();
    test_compare();
    test_back_to_back();
    test_wrong_path();
    test_random();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
